// File: rtl/ospi_rd_deser.sv
// OSPI read-data deserialiser: waits out the dummy cycles, packs DDR byte pairs
// into little-endian 32-bit words and buffers them in a first-word-fall-through FIFO.
module ospi_rd_deser #(
  parameter int LAT_W      = 5,
  parameter int LEN_W      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [7:0]       dp_i,
  input  logic [7:0]       dn_i,
  input  logic             start,
  input  logic [LAT_W-1:0] lat,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [31:0]      rd_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic             overflow,
  input  logic             clear_ovf
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [LAT_W-1:0]   lat_cnt_q, lat_cnt_d;
  logic [LEN_W-1:0]   word_cnt_q, word_cnt_d;
  logic               half_q, half_d;
  logic [15:0]        hold_q, hold_d;
  logic               done_q, done_d;
  logic               overflow_q, overflow_d;

  logic [31:0]        mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q;

  logic               push_s;
  logic [31:0]        push_data_s;
  logic               flush_s;
  logic               pop_s;
  logic               full_s;
  logic               wr_en_s;
  logic               drop_s;

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      lat_cnt_q  <= {LAT_W{1'b0}};
      word_cnt_q <= {LEN_W{1'b0}};
      half_q     <= 1'b0;
      hold_q     <= 16'h0000;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lat_cnt_q  <= lat_cnt_d;
      word_cnt_q <= word_cnt_d;
      half_q     <= half_d;
      hold_q     <= hold_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
    end
  end

  // Next-state, counters, pair packing and FIFO push request
  always_comb begin
    state_d     = state_q;
    lat_cnt_d   = lat_cnt_q;
    word_cnt_d  = word_cnt_q;
    half_d      = half_q;
    hold_d      = hold_q;
    done_d      = 1'b0;
    push_s      = 1'b0;
    push_data_s = 32'h0000_0000;
    flush_s     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (abort) begin
          flush_s = 1'b1;
        end else if (start) begin
          if (len != {LEN_W{1'b0}}) begin
            lat_cnt_d  = lat;
            word_cnt_d = len;
            half_d     = 1'b0;
            hold_d     = 16'h0000;
            state_d    = (lat == {LAT_W{1'b0}}) ? S_DATA : S_WAIT;
          end else begin
            done_d = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_WAIT: begin
        if (abort) begin
          flush_s    = 1'b1;
          state_d    = S_IDLE;
          lat_cnt_d  = {LAT_W{1'b0}};
          word_cnt_d = {LEN_W{1'b0}};
          half_d     = 1'b0;
          hold_d     = 16'h0000;
        end else if (lat_cnt_q <= {{(LAT_W-1){1'b0}}, 1'b1}) begin
          lat_cnt_d = {LAT_W{1'b0}};
          state_d   = S_DATA;
        end else begin
          lat_cnt_d = lat_cnt_q - {{(LAT_W-1){1'b0}}, 1'b1};
        end
      end

      S_DATA: begin
        if (abort) begin
          flush_s    = 1'b1;
          state_d    = S_IDLE;
          word_cnt_d = {LEN_W{1'b0}};
          half_d     = 1'b0;
          hold_d     = 16'h0000;
        end else begin
          half_d = ~half_q;
          if (!half_q) begin
            hold_d = {dn_i, dp_i};
          end else begin
            // Second pair of the word completes it: dp_i lands in [23:16], dn_i in [31:24]
            push_s      = 1'b1;
            push_data_s = {dn_i, dp_i, hold_q};
            word_cnt_d  = word_cnt_q - {{(LEN_W-1){1'b0}}, 1'b1};
            if (word_cnt_q == {{(LEN_W-1){1'b0}}, 1'b1}) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = S_DATA;
            end
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign rd_valid = (count_q != {CNT_W{1'b0}});
  assign full_s   = (count_q == CNT_W'(FIFO_DEPTH));
  assign pop_s    = rd_valid && rd_ready;
  // The PHY cannot be stalled, so a push into a full FIFO without a pop is dropped
  assign wr_en_s  = push_s && !flush_s && (!full_s || pop_s);
  assign drop_s   = push_s && !flush_s && full_s && !pop_s;

  // Sticky overflow; a new drop wins over a simultaneous clear
  always_comb begin
    if (drop_s) begin
      overflow_d = 1'b1;
    end else if (clear_ovf) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // FIFO storage, pointers and occupancy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 32'h0000_0000;
      end
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else if (flush_s) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      if (wr_en_s) begin
        mem_q[wr_ptr_q] <= push_data_s;
        wr_ptr_q        <= wr_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
      end
      if (wr_en_s && !pop_s) begin
        count_q <= count_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else if (pop_s && !wr_en_s) begin
        count_q <= count_q - {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        count_q <= count_q;
      end
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign overflow = overflow_q;
  assign rd_data  = rd_valid ? mem_q[rd_ptr_q] : 32'h0000_0000;

endmodule

// File: tb/tb_ospi_rd_deser.sv
// Self-checking bench for ospi_rd_deser: random pair streams checked cycle by
// cycle against a queue model built from the burst timing rules.
module tb_ospi_rd_deser;
  localparam int FD = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  dp_i, dn_i;
  logic        start;
  logic [4:0]  lat;
  logic [7:0]  len;
  logic        abort;
  logic        busy, done;
  logic [31:0] rd_data;
  logic        rd_valid, rd_ready, overflow, clear_ovf;

  int total = 0;
  int bad   = 0;

  logic [31:0] mq[$];
  bit          m_ovf;

  ospi_rd_deser #(.LAT_W(5), .LEN_W(8), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .reset_n(reset_n), .dp_i(dp_i), .dn_i(dn_i),
    .start(start), .lat(lat), .len(len), .abort(abort),
    .busy(busy), .done(done), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .overflow(overflow), .clear_ovf(clear_ovf)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    @(posedge clk); #1;
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; rd_ready = 1'b0; clear_ovf = 1'b0;
    dp_i = 8'h00; dn_i = 8'h00; lat = 5'd0; len = 8'd0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    mq.delete();
    m_ovf = 1'b0;
  endtask

  // One burst request plus drain cycles; every edge is checked against the model.
  // Pair p (0-based) is sampled at edge lat+1+p after the accept edge 0.
  task automatic run_burst(input int lat_v, input int len_v, input int ready_pct,
                           input int abort_e, input bit fixed, input bit mid_start);
    int e_last, last_busy, p;
    bit ended, pop, full, exp_busy, exp_done;
    logic [15:0] m_hold;
    logic [31:0] w;
    e_last    = (len_v == 0) ? 0 : lat_v + 2 * len_v;
    last_busy = (abort_e >= 0) ? abort_e : e_last;
    ended     = 1'b0;
    m_hold    = 16'h0000;
    for (int e = 0; e <= e_last + 12; e++) begin
      p        = e - (lat_v + 1);
      start    = (e == 0) || (mid_start && e >= 1 && e <= last_busy && $urandom_range(2) == 0);
      lat      = (e == 0) ? 5'(lat_v) : 5'($urandom);
      len      = (e == 0) ? 8'(len_v) : 8'($urandom_range(255, 1));
      abort    = (e == abort_e);
      rd_ready = ($urandom_range(99) < ready_pct);
      if (fixed && p >= 0) begin
        dp_i = 8'(8'h11 + 34 * p);
        dn_i = 8'(8'h22 + 34 * p);
      end else begin
        dp_i = 8'($urandom);
        dn_i = 8'($urandom);
      end
      @(posedge clk);
      full     = (mq.size() == FD);
      pop      = (mq.size() != 0) && rd_ready;
      exp_done = 1'b0;
      if (!ended && e == 0) begin
        if (len_v == 0) begin
          exp_done = 1'b1;
          ended    = 1'b1;
        end
        if (pop) void'(mq.pop_front());
      end else if (!ended && abort) begin
        mq.delete();
        ended = 1'b1;
      end else begin
        if (pop) void'(mq.pop_front());
        if (!ended && p >= 0 && p < 2 * len_v) begin
          if (p % 2 == 0) begin
            m_hold = {dn_i, dp_i};
          end else begin
            w = {dn_i, dp_i, m_hold};
            if (!full || pop) mq.push_back(w);
            else m_ovf = 1'b1;
            if (p == 2 * len_v - 1) begin
              exp_done = 1'b1;
              ended    = 1'b1;
            end
          end
        end
      end
      exp_busy = !ended;
      #1;
      total++;
      if (rd_valid !== (mq.size() != 0)) begin
        bad++; $display("FAIL rd_valid e=%0d got=%b exp=%b", e, rd_valid, mq.size() != 0);
      end
      if (mq.size() != 0) begin
        total++;
        if (rd_data !== mq[0]) begin
          bad++; $display("FAIL rd_data e=%0d got=%h exp=%h", e, rd_data, mq[0]);
        end
      end
      total++;
      if (busy !== exp_busy) begin
        bad++; $display("FAIL busy e=%0d got=%b exp=%b", e, busy, exp_busy);
      end
      total++;
      if (done !== exp_done) begin
        bad++; $display("FAIL done e=%0d got=%b exp=%b", e, done, exp_done);
      end
      total++;
      if (overflow !== m_ovf) begin
        bad++; $display("FAIL overflow e=%0d got=%b exp=%b", e, overflow, m_ovf);
      end
    end
    start = 1'b0; abort = 1'b0; rd_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (busy !== 1'b0)         begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0)         begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (rd_valid !== 1'b0)     begin bad++; $display("FAIL reset_valid got=%b exp=0", rd_valid); end
    total++; if (rd_data !== 32'h0)     begin bad++; $display("FAIL reset_data got=%h exp=0", rd_data); end
    total++; if (overflow !== 1'b0)     begin bad++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
  endtask

  task automatic test_basic();
    do_reset();
    run_burst(0, 1, 0, -1, 1'b1, 1'b0);
    total++;
    if (rd_data !== 32'h4433_2211) begin
      bad++; $display("FAIL basic_word got=%h exp=44332211", rd_data);
    end
  endtask

  task automatic test_latency();
    do_reset();
    run_burst(5, 2, 100, -1, 1'b0, 1'b0);
    run_burst(1, 3, 70, -1, 1'b1, 1'b0);
  endtask

  task automatic test_overflow();
    do_reset();
    run_burst(0, 6, 0, -1, 1'b0, 1'b0);
    total++;
    if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=1", overflow); end
    clear_ovf = 1'b1;
    @(posedge clk); #1;
    clear_ovf = 1'b0;
    m_ovf = 1'b0;
    total++;
    if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
    run_burst(0, 1, 100, -1, 1'b0, 1'b0);
  endtask

  task automatic test_abort();
    do_reset();
    run_burst(0, 4, 0, 4, 1'b0, 1'b0);
    run_burst(2, 2, 50, -1, 1'b0, 1'b0);
  endtask

  task automatic test_len0_and_busy();
    do_reset();
    run_burst(2, 0, 0, -1, 1'b0, 1'b0);
    run_burst(3, 3, 60, -1, 1'b0, 1'b1);
  endtask

  task automatic test_async_reset();
    do_reset();
    start = 1'b1; lat = 5'd0; len = 8'd4; rd_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin
      dp_i = 8'($urandom); dn_i = 8'($urandom);
      @(posedge clk); #1;
    end
    total++; if (rd_valid !== 1'b1) begin bad++; $display("FAIL ar_pre_valid got=%b exp=1", rd_valid); end
    total++; if (busy !== 1'b1)     begin bad++; $display("FAIL ar_pre_busy got=%b exp=1", busy); end
    #2 reset_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0)     begin bad++; $display("FAIL ar_busy got=%b exp=0", busy); end
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL ar_valid got=%b exp=0", rd_valid); end
    total++; if (rd_data !== 32'h0) begin bad++; $display("FAIL ar_data got=%h exp=0", rd_data); end
    total++; if (done !== 1'b0)     begin bad++; $display("FAIL ar_done got=%b exp=0", done); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ar_ovf got=%b exp=0", overflow); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    mq.delete();
    m_ovf = 1'b0;
  endtask

  task automatic test_random();
    int lv, nv, ab;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      lv = $urandom_range(7);
      nv = $urandom_range(8, 1);
      ab = ($urandom_range(3) == 0) ? $urandom_range(lv + 2 * nv, 1) : -1;
      run_burst(lv, nv, $urandom_range(100, 20), ab, 1'b0, $urandom_range(1) == 1);
    end
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; rd_ready = 1'b0; clear_ovf = 1'b0;
    dp_i = 8'h00; dn_i = 8'h00; lat = 5'd0; len = 8'd0;
    m_ovf = 1'b0;
    test_reset();
    test_basic();
    test_latency();
    test_overflow();
    test_abort();
    test_len0_and_busy();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ospi_rd_deser.md
Name: ospi_rd_deser

Overview:
Read-data deserialiser for the OSPI SRAM controller. Sits directly downstream of the DDR input PHY and consumes its rising-edge byte (dp_i) and falling-edge byte (dn_i). Counts out the read latency (dummy) cycles, packs byte pairs into 32-bit words and buffers them in a small FIFO toward the bus-side read port.

Parameters:
LAT_W, 5, width of the latency (dummy-cycle) count.
LEN_W, 8, width of the burst length in 32-bit words.
FIFO_DEPTH, 4, read FIFO entries (power of two, at least 2).

Ports:
clk  in  1  controller clock, same clock as the DDR input PHY.
reset_n  in  1  reset, asynchronous assert, active-low.
dp_i  in  8  byte captured on the rising edge by the PHY.
dn_i  in  8  byte captured on the falling edge by the PHY.
start  in  1  burst request pulse; accepted only in IDLE.
lat  in  LAT_W  dummy cycles before the first data pair; sampled with start.
len  in  LEN_W  burst length in words; sampled with start.
abort  in  1  cancel the current burst.
busy  out  1  high while in WAIT or DATA.
done  out  1  one-cycle pulse at the end of a burst.
rd_data  out  32  FIFO head word.
rd_valid  out  1  FIFO not empty.
rd_ready  in  1  consumer pops the head when rd_valid is also high.
overflow  out  1  sticky; a word was dropped because the FIFO was full.
clear_ovf  in  1  clears overflow.

Behaviour:
- Reset (reset_n low, asynchronous):
  - State goes to IDLE.
  - busy=0, done=0, rd_valid=0, rd_data=0, overflow=0.
  - FIFO is emptied, the half-word register is cleared and all counters are 0.
- Pair sampling:
  - At a posedge, dp_i and dn_i are sampled together as one pair; dp_i is the first byte, dn_i the second.
  - Byte order is little-endian. The first pair fills [7:0]=dp_i and [15:8]=dn_i. The second pair fills [23:16]=dp_i and [31:24]=dn_i.
- FSM states: IDLE, WAIT, DATA.
- IDLE:
  - start=1 and len!=0: load the latency counter from lat, load the word counter from len, clear the half flag. Go to WAIT, or to DATA if lat==0.
  - start=1 and len==0: stay in IDLE and pulse done on the next cycle. busy stays 0.
  - start in any other state is ignored.
- WAIT:
  - The latency counter decrements each cycle.
  - When the counter reaches 1, the state moves to DATA on the next edge.
  - Result: the first pair is sampled at edge lat+1 after the start-accept edge.
- DATA:
  - Every edge samples one pair and toggles the half flag.
  - On a half=0 edge, the pair goes into the low 16-bit holding register.
  - On a half=1 edge, the full word is written into the FIFO and the word counter decrements.
  - When the counter reaches 0, the state returns to IDLE and done=1 for the following cycle.
- Latency example: with lat=0 and start accepted at edge E0, pairs are sampled at E1 and E2. rd_valid is high after E2, and done is high in the cycle after E2.
- FIFO behaviour:
  - First-word fall-through; rd_data shows the head whenever rd_valid=1.
  - A pop occurs when rd_valid and rd_ready are both high.
  - Push onto a full FIFO with no pop in the same cycle: the word is dropped and overflow is set. The FSM keeps running (the OSPI clock cannot be stalled).
  - Push and pop together on a full FIFO: the push is accepted.
  - Pop on an empty FIFO: no effect.
- overflow:
  - Set on a dropped word.
  - Cleared by clear_ovf.
  - If set and clear happen in the same cycle, set wins.
- abort:
  - In WAIT or DATA: go to IDLE on the next edge, discard the half word, flush the FIFO. No done pulse.
  - In IDLE: flushes the FIFO only.
  - abort has priority over start.
- Counters are unsigned and never wrap. len is limited to 2^LEN_W-1 words.

Test Plan:
- lat=0, len=1; dp/dn pairs (11,22) then (33,44) -> rd_data=32'h44332211, rd_valid high after edge 2, done pulses for one cycle, busy low afterwards.
- lat=5, len=2, rd_ready=1; four pairs supplied starting at edge 6 -> no FIFO write before edge 7; two words in order; done follows the second write.
- FIFO_DEPTH=4, len=6, rd_ready=0 -> 4 words held, words 5 and 6 dropped, overflow=1. A later clear_ovf returns overflow to 0.
- len=4 with abort asserted after 3 pairs -> FSM returns to IDLE, rd_valid=0, no done pulse. A new start then completes normally.
- Async reset_n asserted mid-DATA with 2 words buffered -> all outputs 0 immediately, without waiting for a clock edge.
- start with len=0 -> done pulses once, busy never rises. start while busy -> ignored, word count unchanged.
